// File: rtl/upsp_ac_pkg.sv
// Shared constants and FSM encoding for the AC-side UPSP stream bridge.
// Default geometry is 960x540 upscaled by 4 with 24-bit RGB pixels.
package upsp_ac_pkg;

  localparam int PIX_W_DEF      = 24;
  localparam int LANES_DEF      = 4;
  localparam int SRC_WIDTH_DEF  = 960;
  localparam int SRC_HEIGHT_DEF = 540;
  localparam int SCALE_DEF      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage : upsp_ac_pkg

// File: rtl/ac_pixel_serializer.sv
// Unpacks one LANES-pixel result word into a 1-pixel/beat stream.
// A new word may load in the same cycle the last lane handshakes, so words stream without bubbles.
module ac_pixel_serializer
  import upsp_ac_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   wvalid_i,
  input  logic [PIX_W*LANES-1:0] wdata_i,
  output logic                   wready_o,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic [PIX_W-1:0]       m_data_o
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [LANES-1:0][PIX_W-1:0] word_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        m_valid_q;
  logic                        w_fire;
  logic                        m_fire;

  // Only combinational path in the bridge: m_ready lets the final lane hand over to the next word.
  assign wready_o = en_i && (!m_valid_q || ((idx_q == LAST_IDX) && m_ready_i));
  assign w_fire   = wvalid_i && wready_o;
  assign m_fire   = m_valid_q && m_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
    end else if (w_fire) begin
      word_q    <= wdata_i;
      idx_q     <= '0;
      m_valid_q <= 1'b1;
    end else if (m_fire) begin
      if (idx_q == LAST_IDX) begin
        m_valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = word_q[idx_q];

endmodule : ac_pixel_serializer

// File: rtl/ac_upsp_stream_bridge.sv
// AC-side bridge: feeds source pixels to the UPSP read channel through a 2-entry skid buffer
// and serializes UPSP result words into a marked 1-pixel/beat output stream, one frame per start.
module ac_upsp_stream_bridge
  import upsp_ac_pkg::*;
#(
  parameter int SRC_WIDTH  = SRC_WIDTH_DEF,
  parameter int SRC_HEIGHT = SRC_HEIGHT_DEF,
  parameter int SCALE      = SCALE_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int LANES      = LANES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  output logic                   busy,
  output logic                   frame_done,
  input  logic                   s_valid,
  input  logic [PIX_W-1:0]       s_data,
  output logic                   s_ready,
  output logic                   ac_upsp_rvalid,
  output logic [PIX_W-1:0]       ac_upsp_rdata,
  input  logic                   upsp_ac_rready,
  input  logic                   upsp_ac_wvalid,
  input  logic [PIX_W*LANES-1:0] upsp_ac_wdata,
  output logic                   ac_upsp_wready,
  output logic                   m_valid,
  output logic [PIX_W-1:0]       m_data,
  output logic                   m_eol,
  output logic                   m_eof,
  input  logic                   m_ready
);

  localparam int SRC_TOTAL = SRC_WIDTH * SRC_HEIGHT;
  localparam int DST_WIDTH = SRC_WIDTH * SCALE;
  localparam int DST_TOTAL = DST_WIDTH * SRC_HEIGHT * SCALE;
  localparam int SRC_CNT_W = $clog2(SRC_TOTAL + 1);
  localparam int COL_W     = $clog2(DST_WIDTH + 1);
  localparam int DST_CNT_W = $clog2(DST_TOTAL + 1);

  localparam logic [SRC_CNT_W-1:0] SRC_TOTAL_C = SRC_CNT_W'(SRC_TOTAL);
  localparam logic [COL_W-1:0]     COL_LAST    = COL_W'(DST_WIDTH - 1);
  localparam logic [DST_CNT_W-1:0] DST_LAST    = DST_CNT_W'(DST_TOTAL - 1);

  if ((DST_WIDTH % LANES) != 0) begin : g_bad_geometry
    $error("DST_WIDTH must be a multiple of LANES");
  end

  state_e               state_q;
  logic                 busy_q;
  logic                 frame_done_q;
  logic [SRC_CNT_W-1:0] src_cnt_q;
  logic [COL_W-1:0]     dst_col_q;
  logic [DST_CNT_W-1:0] dst_cnt_q;
  logic [1:0]           ent_q;
  logic [PIX_W-1:0]     skid_q [2];

  logic start_ok;
  logic s_fire;
  logic r_fire;
  logic m_fire;
  logic eof_fire;

  assign start_ok = (state_q == ST_IDLE) && frame_start;
  assign s_fire   = s_valid && s_ready;
  assign r_fire   = ac_upsp_rvalid && upsp_ac_rready;
  assign m_fire   = m_valid && m_ready;
  assign eof_fire = m_fire && m_eof;

  // Built only from registers, so upsp_ac_rready never reaches s_ready combinationally.
  assign s_ready        = (state_q == ST_RUN) && (src_cnt_q < SRC_TOTAL_C) && (ent_q != 2'd2);
  assign ac_upsp_rvalid = (ent_q != 2'd0);
  assign ac_upsp_rdata  = skid_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if ((src_cnt_q == SRC_TOTAL_C) && (ent_q == 2'd0)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (eof_fire) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_cnt_q <= '0;
      dst_col_q <= '0;
      dst_cnt_q <= '0;
    end else if (start_ok) begin
      src_cnt_q <= '0;
      dst_col_q <= '0;
      dst_cnt_q <= '0;
    end else begin
      if (s_fire && (src_cnt_q < SRC_TOTAL_C)) begin
        src_cnt_q <= src_cnt_q + 1'b1;
      end
      if (m_fire) begin
        dst_col_q <= (dst_col_q == COL_LAST) ? '0 : dst_col_q + 1'b1;
        dst_cnt_q <= dst_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the two skid entries are reset because ac_upsp_rdata exposes the head directly and must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q     <= 2'd0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      case ({s_fire, r_fire})
        2'b10: begin
          skid_q[ent_q[0]] <= s_data;
          ent_q            <= ent_q + 2'd1;
        end
        2'b01: begin
          skid_q[0] <= skid_q[1];
          ent_q     <= ent_q - 2'd1;
        end
        2'b11: begin
          if (ent_q == 2'd1) begin
            skid_q[0] <= s_data;
          end else begin
            skid_q[0] <= skid_q[1];
            skid_q[1] <= s_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  ac_pixel_serializer #(
    .PIX_W (PIX_W),
    .LANES (LANES)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q != ST_IDLE),
    .wvalid_i  (upsp_ac_wvalid),
    .wdata_i   (upsp_ac_wdata),
    .wready_o  (ac_upsp_wready),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data)
  );

  assign m_eol = m_valid && (dst_col_q == COL_LAST);
  assign m_eof = m_valid && (dst_cnt_q == DST_LAST);

endmodule : ac_upsp_stream_bridge

// File: tb/tb_ac_upsp_stream_bridge.sv
// Directed bench for ac_upsp_stream_bridge on a 4x2 source upscaled by 4 (8 source pixels, 128 output pixels).
module tb_ac_upsp_stream_bridge;
  import upsp_ac_pkg::*;

  localparam int PIX_W     = 24;
  localparam int LANES     = 4;
  localparam int N_SRC     = 8;
  localparam int N_DST     = 128;
  localparam int DST_W     = 16;
  localparam int N_WORDS   = N_DST / LANES;
  localparam int CYC_LIMIT = 4000;

  logic                   clk;
  logic                   rst_n;
  logic                   frame_start;
  logic                   busy;
  logic                   frame_done;
  logic                   s_valid;
  logic [PIX_W-1:0]       s_data;
  logic                   s_ready;
  logic                   ac_upsp_rvalid;
  logic [PIX_W-1:0]       ac_upsp_rdata;
  logic                   upsp_ac_rready;
  logic                   upsp_ac_wvalid;
  logic [PIX_W*LANES-1:0] upsp_ac_wdata;
  logic                   ac_upsp_wready;
  logic                   m_valid;
  logic [PIX_W-1:0]       m_data;
  logic                   m_eol;
  logic                   m_eof;
  logic                   m_ready;

  int n_checks = 0;
  int n_pass   = 0;

  ac_upsp_stream_bridge #(
    .SRC_WIDTH  (4),
    .SRC_HEIGHT (2),
    .SCALE      (4),
    .PIX_W      (PIX_W),
    .LANES      (LANES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .busy           (busy),
    .frame_done     (frame_done),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .ac_upsp_rvalid (ac_upsp_rvalid),
    .ac_upsp_rdata  (ac_upsp_rdata),
    .upsp_ac_rready (upsp_ac_rready),
    .upsp_ac_wvalid (upsp_ac_wvalid),
    .upsp_ac_wdata  (upsp_ac_wdata),
    .ac_upsp_wready (ac_upsp_wready),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_eol          (m_eol),
    .m_eof          (m_eof),
    .m_ready        (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  // Word j carries output pixels 4j+1 .. 4j+4, lane 0 in the low bits.
  function automatic logic [PIX_W*LANES-1:0] make_word(input int j);
    logic [PIX_W*LANES-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) w[k*PIX_W +: PIX_W] = PIX_W'(j * LANES + k + 1);
    return w;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Drives source pixels (values 1..8) and result words, checking every handshake against the expected order.
  task automatic frame_loop(input bit rnd, input bit do_src, input int max_words);
    int src_next = do_src ? 1 : N_SRC + 1;
    int r_exp    = do_src ? 1 : N_SRC + 1;
    int w_idx    = 0;
    int p_exp    = 1;
    int cyc      = 0;
    bit stall    = 1'b0;
    logic [PIX_W-1:0] st_data = '0;
    logic st_eol = 1'b0;
    logic st_eof = 1'b0;
    while ((p_exp <= max_words * LANES) && (cyc < CYC_LIMIT)) begin
      @(negedge clk);
      s_valid        = (src_next <= N_SRC) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      s_data         = PIX_W'(src_next);
      upsp_ac_rready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      upsp_ac_wvalid = (w_idx < max_words) && (r_exp > N_SRC);
      upsp_ac_wdata  = make_word(w_idx);
      m_ready        = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      check("done_early", frame_done, 1'b0);
      if (stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, st_data);
        check("stall_eol", m_eol, st_eol);
        check("stall_eof", m_eof, st_eof);
      end
      if (ac_upsp_rvalid && upsp_ac_rready) begin
        check("rdata", ac_upsp_rdata, PIX_W'(r_exp));
        r_exp++;
      end
      if (s_valid && s_ready) src_next++;
      if (!rnd && max_words == N_WORDS && p_exp > 1) check("no_bubble", m_valid, 1'b1);
      if (!rnd && m_valid) check("wready_lane", ac_upsp_wready, (p_exp % LANES) == 0);
      if (m_valid && m_ready) begin
        check("m_data", m_data, PIX_W'(p_exp));
        check("m_eol", m_eol, (p_exp % DST_W) == 0);
        check("m_eof", m_eof, p_exp == N_DST);
        p_exp++;
      end
      stall   = m_valid && !m_ready;
      st_data = m_data;
      st_eol  = m_eol;
      st_eof  = m_eof;
      if (upsp_ac_wvalid && ac_upsp_wready) w_idx++;
      cyc++;
    end
    check("loop_in_time", cyc < CYC_LIMIT, 1'b1);
    if (do_src) check("src_all_once", r_exp, N_SRC + 1);
    if (max_words == N_WORDS) begin
      @(negedge clk);
      upsp_ac_wvalid = 1'b0;
      s_valid        = 1'b0;
      m_ready        = 1'b1;
      #1;
      check("frame_done", frame_done, 1'b1);
      check("busy_fall", busy, 1'b0);
      check("state_idle", dut.state_q, ST_IDLE);
      check("m_valid_end", m_valid, 1'b0);
      @(negedge clk);
      #1;
      check("done_pulse", frame_done, 1'b0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    frame_start    = 1'b0;
    s_valid        = 1'b0;
    s_data         = '0;
    upsp_ac_rready = 1'b0;
    upsp_ac_wvalid = 1'b0;
    upsp_ac_wdata  = '0;
    m_ready        = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_sready", s_ready, 1'b0);
    check("rst_rvalid", ac_upsp_rvalid, 1'b0);
    check("rst_rdata", ac_upsp_rdata, '0);
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_mdata", m_data, '0);
    check("rst_marks", {m_eol, m_eof, frame_done}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Result word while idle must not be acknowledged.
    @(negedge clk);
    upsp_ac_wvalid = 1'b1;
    upsp_ac_wdata  = make_word(0);
    m_ready        = 1'b1;
    #1;
    check("idle_wready", ac_upsp_wready, 1'b0);
    @(negedge clk);
    #1;
    check("idle_no_load", m_valid, 1'b0);
    check("idle_state", dut.state_q, ST_IDLE);
    upsp_ac_wvalid = 1'b0;

    // Source stream 1..8 back-to-back; a second frame_start mid-run is ignored.
    pulse_start();
    #1;
    check("run_busy", busy, 1'b1);
    for (int k = 1; k <= N_SRC; k++) begin
      @(negedge clk);
      s_valid        = 1'b1;
      s_data         = PIX_W'(k);
      upsp_ac_rready = 1'b1;
      frame_start    = (k == 4);
      #1;
      check("s_ready_run", s_ready, 1'b1);
      check("rvalid_seq", ac_upsp_rvalid, k > 1);
      if (k > 1) check("rdata_seq", ac_upsp_rdata, PIX_W'(k - 1));
      if (k == 5) check("restart_ignored", dut.state_q, ST_RUN);
    end
    @(negedge clk);
    frame_start = 1'b0;
    s_data      = PIX_W'(99);
    #1;
    check("s_ready_sat", s_ready, 1'b0);
    check("rdata_last", ac_upsp_rdata, PIX_W'(8));
    @(negedge clk);
    #1;
    check("no_extra_pix", ac_upsp_rvalid, 1'b0);
    check("still_run", dut.state_q, ST_RUN);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("drain", dut.state_q, ST_DRAIN);
    check("drain_busy", busy, 1'b1);

    // 32 words with m_ready held high.
    frame_loop(1'b0, 1'b0, N_WORDS);

    // Both channels randomly stalled.
    pulse_start();
    frame_loop(1'b1, 1'b1, N_WORDS);

    // Reset in the middle of DRAIN with a word half-held.
    pulse_start();
    frame_loop(1'b0, 1'b1, 3);
    @(negedge clk);
    upsp_ac_wvalid = 1'b1;
    upsp_ac_wdata  = make_word(3);
    m_ready        = 1'b0;
    @(negedge clk);
    upsp_ac_wvalid = 1'b0;
    #1;
    check("pre_rst_valid", m_valid, 1'b1);
    check("pre_rst_state", dut.state_q, ST_DRAIN);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_mvalid", m_valid, 1'b0);
    check("mid_rst_mdata", m_data, '0);
    check("mid_rst_wready", ac_upsp_wready, 1'b0);
    check("mid_rst_done", frame_done, 1'b0);
    check("mid_rst_read", {s_ready, ac_upsp_rvalid, m_eol, m_eof}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_done", frame_done, 1'b0);
    check("post_rst_state", dut.state_q, ST_IDLE);
    pulse_start();
    frame_loop(1'b0, 1'b1, N_WORDS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ac_upsp_stream_bridge
